// File: rtl/cga_fetch_pkg.sv
// cga_fetch_pkg: shared types, widths and address-step helper for the CGA VRAM fetcher.
// Build option: CGA_VRAM_WRAP_EN -- when defined, address increments wrap within a 16 KiB window.
package cga_fetch_pkg;

  localparam int unsigned SRAM_AW            = 21;
  localparam int unsigned DATA_W             = 8;
  localparam int unsigned BYTES_PER_LINE_DEF = 160;
  localparam int unsigned FIFO_DEPTH_DEF     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Next request address: 6845-style 16 KiB wrap, or a plain 21-bit increment.
  function automatic logic [SRAM_AW-1:0] next_addr(input logic [SRAM_AW-1:0] a);
`ifdef CGA_VRAM_WRAP_EN
    return {a[SRAM_AW-1:14], a[13:0] + 14'd1};
`else
    return a + SRAM_AW'(1);
`endif
  endfunction

endpackage

// File: rtl/cga_vram_fetcher_if.sv
// cga_vram_fetcher_if: CGA read port between the fetcher (master) and the SRAM arbiter (slave).
interface cga_vram_fetcher_if;
  import cga_fetch_pkg::*;

  logic               enacga;
  logic [SRAM_AW-1:0] addracga;
  logic               cga_grant;
  logic [DATA_W-1:0]  doutacga;

  modport master (output enacga, addracga, input cga_grant, doutacga);
  modport slave  (input enacga, addracga, output cga_grant, doutacga);

endinterface

// File: rtl/cga_fetch_fifo.sv
// cga_fetch_fifo: single-clock FIFO with registered head byte, occupancy output and flush.
module cga_fetch_fifo
  import cga_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned W     = DATA_W
) (
  input  logic                   clka,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0] after_pop, level_nxt;
  logic          do_push, do_pop;

  // Qualified push/pop and the next-state occupancy/pointer values.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (level != LW'(DEPTH));
    after_pop  = level - LW'(do_pop);
    level_nxt  = after_pop + LW'(do_push);
    rd_ptr_nxt = rd_ptr + AW'(do_pop);
  end

  // Storage array write.
  always_ff @(posedge clka) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head; a byte pushed into an empty FIFO becomes head directly.
  always_ff @(posedge clka) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      empty  <= (level_nxt == '0);
      if (level_nxt != '0) dout <= (after_pop == '0) ? din : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/cga_vram_fetcher.sv
// cga_vram_fetcher: prefetches one scanline of CGA video bytes from the shared SRAM into a local FIFO.
// Build option: CGA_VRAM_WRAP_EN -- request addresses wrap within a 16 KiB window.
module cga_vram_fetcher
  import cga_fetch_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = BYTES_PER_LINE_DEF,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int unsigned RD_LATENCY     = 2
) (
  input  logic                        clka,
  input  logic                        reset,
  input  logic                        line_start,
  input  logic [SRAM_AW-1:0]          line_base,
  cga_vram_fetcher_if.master          bus,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        underflow
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RW = $clog2(BYTES_PER_LINE + 1);

  fetch_state_e          state;
  logic [SRAM_AW-1:0]    addr_q;
  logic                  req_q;
  logic [RW-1:0]         remaining;
  logic [RD_LATENCY-1:0] vpipe, vpipe_nxt;
  logic                  restart, accept, push, pop, credit_ok;
  logic [LW-1:0]         level_nxt;
  int unsigned           inflight_nxt;

  assign bus.enacga   = req_q;
  assign bus.addracga = addr_q;

  // Handshake qualification, return tracking and the issue credit for the next cycle.
  always_comb begin
    restart   = line_start && (state != IDLE);
    accept    = req_q && bus.cga_grant && !restart;
    push      = vpipe[RD_LATENCY-1] && !restart;
    pop       = rd_en && !empty && !restart;
    vpipe_nxt = restart ? '0 : ((vpipe << 1) | RD_LATENCY'(accept));
    level_nxt = restart ? '0 : (level + LW'(push) - LW'(pop));
    inflight_nxt = 0;
    for (int i = 0; i < RD_LATENCY; i++) inflight_nxt += 32'(vpipe_nxt[i]);
    credit_ok = (32'(level_nxt) + inflight_nxt) < FIFO_DEPTH;
  end

  // Fetch FSM: request issue, address stepping, return pipe and busy flag.
  always_ff @(posedge clka) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      vpipe     <= '0;
      req_q     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      vpipe <= vpipe_nxt;
      if (line_start) begin
        state     <= FETCH;
        addr_q    <= line_base;
        remaining <= RW'(BYTES_PER_LINE);
        req_q     <= credit_ok;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            req_q <= 1'b0;
            busy  <= (level_nxt != '0);
          end
          FETCH: begin
            busy <= 1'b1;
            if (accept) begin
              addr_q    <= next_addr(addr_q);
              remaining <= remaining - RW'(1);
              if (remaining == RW'(1)) begin
                state <= DRAIN;
                req_q <= 1'b0;
              end else begin
                req_q <= credit_ok;
              end
            end else begin
              req_q <= credit_ok;
            end
          end
          DRAIN: begin
            req_q <= 1'b0;
            busy  <= 1'b1;
            if (vpipe_nxt == '0) begin
              state <= IDLE;
              busy  <= (level_nxt != '0);
            end
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky flag for a pop attempted on an empty FIFO.
  always_ff @(posedge clka) begin
    if (reset) underflow <= 1'b0;
    else if (rd_en && empty && !restart) underflow <= 1'b1;
  end

  cga_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clka  (clka),
    .reset (reset),
    .flush (restart),
    .push  (push),
    .din   (bus.doutacga),
    .pop   (pop),
    .dout  (rd_data),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_cga_vram_fetcher.sv
// tb_cga_vram_fetcher: directed checks of the CGA VRAM fetcher against a 2-cycle SRAM read model.
module tb_cga_vram_fetcher;
  import cga_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: 8-byte lines; instance B: 160-byte lines.
  logic        a_reset, a_ls, a_rd, a_empty, a_busy, a_uf;
  logic [20:0] a_base;
  logic [7:0]  a_rdata;
  logic [5:0]  a_level;
  logic        b_reset, b_ls, b_rd, b_empty, b_busy, b_uf;
  logic [20:0] b_base;
  logic [7:0]  b_rdata;
  logic [5:0]  b_level;

  cga_vram_fetcher_if if_a ();
  cga_vram_fetcher_if if_b ();

  cga_vram_fetcher #(.BYTES_PER_LINE(8), .FIFO_DEPTH(32), .RD_LATENCY(2)) u_a (
    .clka(clk), .reset(a_reset), .line_start(a_ls), .line_base(a_base), .bus(if_a.master),
    .rd_en(a_rd), .rd_data(a_rdata), .empty(a_empty), .level(a_level), .busy(a_busy),
    .underflow(a_uf));

  cga_vram_fetcher #(.BYTES_PER_LINE(160), .FIFO_DEPTH(32), .RD_LATENCY(2)) u_b (
    .clka(clk), .reset(b_reset), .line_start(b_ls), .line_base(b_base), .bus(if_b.master),
    .rd_en(b_rd), .rd_data(b_rdata), .empty(b_empty), .level(b_level), .busy(b_busy),
    .underflow(b_uf));

  // SRAM contents as a function of address.
  function automatic logic [7:0] sram(input logic [20:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // Arbiter read path: byte for a granted request is on doutacga two edges later.
  logic [7:0] a_d1, b_d1;
  always @(posedge clk) begin
    a_d1          <= (if_a.enacga && if_a.cga_grant) ? sram(if_a.addracga) : 8'hEE;
    if_a.doutacga <= a_d1;
    b_d1          <= (if_b.enacga && if_b.cga_grant) ? sram(if_b.addracga) : 8'hEE;
    if_b.doutacga <= b_d1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_level_a(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && a_level != 6'(n); i++) tick();
    check(tag, 32'(a_level), 32'(n));
  endtask

  task automatic drain_a(input logic [20:0] base, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      check(tag, 32'(a_rdata), 32'(sram(base + 21'(k))));
      a_rd = 1'b1;
      tick();
    end
    a_rd = 1'b0;
    check({tag, "_empty"}, 32'(a_empty), 32'd1);
  endtask

  logic [20:0] exp_addr;
  logic [20:0] wexp [4];
  int          wn;
  int          acc;
  int          w;

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; a_ls = 1'b0; b_ls = 1'b0; a_rd = 1'b0; b_rd = 1'b0;
    a_base = '0; b_base = '0;
    if_a.cga_grant = 1'b1; if_b.cga_grant = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_en",    32'(if_a.enacga),   32'd0);
    check("rst_addr",  32'(if_a.addracga), 32'd0);
    check("rst_empty", 32'(a_empty),       32'd1);
    check("rst_level", 32'(a_level),       32'd0);
    check("rst_busy",  32'(a_busy),        32'd0);
    check("rst_uf",    32'(a_uf),          32'd0);
    check("rst_rdata", 32'(a_rdata),       32'd0);
    check("rst_b_empty", 32'(b_empty),     32'd1);
    a_reset = 1'b0; b_reset = 1'b0;

    // Grant always 1: 8 back-to-back requests, then FIFO fills and drains
    a_base = 21'h0B8000; a_ls = 1'b1; tick(); a_ls = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t1_en",   32'(if_a.enacga),   32'd1);
      check("t1_addr", 32'(if_a.addracga), 32'h0B8000 + 32'(i));
      tick();
    end
    check("t1_en_off", 32'(if_a.enacga), 32'd0);
    tick(); tick();
    check("t1_level", 32'(a_level), 32'd8);
    check("t1_busy",  32'(a_busy),  32'd1);
    repeat (2) tick();
    check("t1_busy_hold", 32'(a_busy), 32'd1);
    drain_a(21'h0B8000, 8, "t1_data");
    check("t1_busy_end",  32'(a_busy),  32'd0);
    check("t1_level_end", 32'(a_level), 32'd0);

    // Grant pattern 1,0,0: address holds while not granted, data stays in order
    a_base = 21'h0B8100; a_ls = 1'b1; tick(); a_ls = 1'b0;
    exp_addr = 21'h0B8100; acc = 0;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      if_a.cga_grant = (c % 3 == 0);
      check("t2_en",   32'(if_a.enacga),   32'd1);
      check("t2_addr", 32'(if_a.addracga), 32'(exp_addr));
      if (if_a.cga_grant) begin
        exp_addr = exp_addr + 21'd1;
        acc++;
      end
      tick();
    end
    if_a.cga_grant = 1'b1;
    check("t2_acc", 32'(acc), 32'd8);
    wait_level_a(8, 10, "t2_level");
    drain_a(21'h0B8100, 8, "t2_data");

    // Restart with two reads in flight
    a_base = 21'h0B8200; a_ls = 1'b1; tick(); a_ls = 1'b0;
    tick(); tick();
    check("t5_lvl_pre", 32'(a_level), 32'd0);
    a_base = 21'h0BC000; a_ls = 1'b1; a_rd = 1'b1; tick(); a_ls = 1'b0; a_rd = 1'b0;
    check("t5_empty", 32'(a_empty),       32'd1);
    check("t5_level", 32'(a_level),       32'd0);
    check("t5_en",    32'(if_a.enacga),   32'd1);
    check("t5_addr",  32'(if_a.addracga), 32'h0BC000);
    check("t5_uf",    32'(a_uf),          32'd0);
    tick();
    check("t5_discard", 32'(a_level), 32'd0);
    wait_level_a(8, 20, "t5_level8");
    drain_a(21'h0BC000, 8, "t5_data");

    // Address wrap
`ifdef CGA_VRAM_WRAP_EN
    a_base = 21'h0BBFFE; wn = 4;
    wexp[0] = 21'h0BBFFE; wexp[1] = 21'h0BBFFF; wexp[2] = 21'h0B8000; wexp[3] = 21'h0B8001;
`else
    a_base = 21'h1FFFFF; wn = 2;
    wexp[0] = 21'h1FFFFF; wexp[1] = 21'h000000; wexp[2] = 21'h000001; wexp[3] = 21'h000002;
`endif
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    for (int i = 0; i < wn; i++) begin
      check("t6_addr", 32'(if_a.addracga), 32'(wexp[i]));
      tick();
    end

    // line_start together with reset: reset wins
    a_reset = 1'b1; a_ls = 1'b1; tick(); a_reset = 1'b0; a_ls = 1'b0;
    check("t7_en",    32'(if_a.enacga), 32'd0);
    check("t7_busy",  32'(a_busy),      32'd0);
    check("t7_empty", 32'(a_empty),     32'd1);
    tick();
    check("t7_idle", 32'(if_a.enacga), 32'd0);

    // Underflow is sticky until reset
    a_rd = 1'b1; tick(); a_rd = 1'b0;
    check("t4_uf",    32'(a_uf),    32'd1);
    check("t4_level", 32'(a_level), 32'd0);
    check("t4_empty", 32'(a_empty), 32'd1);
    repeat (3) tick();
    check("t4_sticky", 32'(a_uf), 32'd1);
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    check("t4_clear", 32'(a_uf), 32'd0);

    // 160-byte line through a 32-entry FIFO: credit throttle, then ordered readout
    b_base = 21'h0B8000; b_ls = 1'b1; tick(); b_ls = 1'b0;
    acc = 0;
    for (int c = 0; c < 60 && if_b.enacga; c++) begin
      acc++;
      tick();
    end
    check("t3_credit", 32'(acc), 32'd32);
    repeat (4) tick();
    check("t3_en_low", 32'(if_b.enacga), 32'd0);
    check("t3_level",  32'(b_level),     32'd32);
    for (int k = 0; k < 160; k++) begin
      w = 0;
      while (b_empty && w < 20) begin
        tick();
        w++;
      end
      check("t3_wait", 32'(b_empty), 32'd0);
      check("t3_data", 32'(b_rdata), 32'(sram(21'(32'h0B8000 + 32'(k)))));
      b_rd = 1'b1; tick(); b_rd = 1'b0;
      if (k == 0) check("t3_resume", 32'(if_b.enacga), 32'd1);
    end
    tick();
    check("t3_empty", 32'(b_empty), 32'd1);
    check("t3_busy",  32'(b_busy),  32'd0);
    check("t3_uf",    32'(b_uf),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
